// File: rtl/ccx_emem_width_bridge.sv
// ccx_emem_width_bridge: splits each 64-bit core memory access into one or two
// registered external beats on a 32- or 64-bit bus, merges read data and keeps
// beat errors sticky. Empty write beats can be elided.
//
// Handshake: a requester raises req with stable fields and holds them until it
// sees gnt; gnt is a single-cycle response carrying rdata/err. This holds for
// both the core side (c_req/c_gnt) and the external side (x_req/x_gnt).
module ccx_emem_width_bridge #(
  parameter int ADDR_W           = 39,
  parameter int EXT_DW           = 32,
  parameter bit SKIP_EMPTY_BEATS = 1'b1
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                c_req,
  input  logic                c_rtype,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic                c_wen,
  input  logic [7:0]          c_strb,
  input  logic [63:0]         c_wdata,
  output logic                c_gnt,
  output logic                c_err,
  output logic [63:0]         c_rdata,
  output logic                x_req,
  output logic                x_rtype,
  output logic [ADDR_W-1:0]   x_addr,
  output logic                x_wen,
  output logic [EXT_DW/8-1:0] x_strb,
  output logic [EXT_DW-1:0]   x_wdata,
  input  logic                x_gnt,
  input  logic                x_err,
  input  logic [EXT_DW-1:0]   x_rdata,
  output logic                busy
);

  localparam int SW = EXT_DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                hold_q, hold_d;
  logic                rtype_q, wen_q, need1_q;
  logic [ADDR_W-1:3]   addr_q;
  logic [7:0]          strb_q;
  logic [63:0]         wdata_q;
  logic [63:0]         acc_q, acc_d;
  logic                sticky_q, sticky_d;

  // Request fields come straight from the core while idle, from the captured copy otherwise.
  logic                src_rtype, src_wen;
  logic [ADDR_W-1:3]   src_addr;
  logic [7:0]          src_strb;
  logic [63:0]         src_wdata;
  logic [SW-1:0]       slc_strb0, slc_strb1;
  logic [EXT_DW-1:0]   slc_wd0, slc_wd1;
  logic                need0, need1;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^c_addr[2:0];

  // Select the live or captured request as the source of beat fields.
  always_comb begin
    src_rtype = rtype_q;
    src_wen   = wen_q;
    src_addr  = addr_q;
    src_strb  = strb_q;
    src_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      src_rtype = c_rtype;
      src_wen   = c_wen;
      src_addr  = c_addr[ADDR_W-1:3];
      src_strb  = c_strb;
      src_wdata = c_wdata;
    end
  end

  if (EXT_DW == 32) begin : g_w32
    assign slc_strb0 = src_strb[3:0];
    assign slc_strb1 = src_strb[7:4];
    assign slc_wd0   = src_wdata[31:0];
    assign slc_wd1   = src_wdata[63:32];
  end else if (EXT_DW == 64) begin : g_w64
    assign slc_strb0 = src_strb;
    assign slc_strb1 = src_strb;
    assign slc_wd0   = src_wdata;
    assign slc_wd1   = src_wdata;
  end else begin : g_bad_width
    $error("ccx_emem_width_bridge: EXT_DW must be 32 or 64");
  end

  // A write beat with no strobes set is elided; reads always need every beat.
  assign need0 = !(SKIP_EMPTY_BEATS && src_wen && (slc_strb0 == '0));
  assign need1 = (EXT_DW == 32) && !(SKIP_EMPTY_BEATS && src_wen && (src_strb[7:4] == 4'h0));

  // Next-state logic plus read-data merge and sticky error accumulation.
  always_comb begin
    state_d  = state_q;
    hold_d   = 1'b0;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    unique case (state_q)
      S_IDLE: begin
        if (c_req) begin
          acc_d    = '0;
          sticky_d = 1'b0;
          if (need0)      state_d = S_BEAT0;
          else if (need1) state_d = S_BEAT1;
          else begin
            // Fully skipped write: one extra RESP cycle so the response
            // lands where a one-beat access would.
            state_d = S_RESP;
            hold_d  = 1'b1;
          end
        end
      end
      S_BEAT0: begin
        if (x_gnt) begin
          if (!wen_q) acc_d[EXT_DW-1:0] = x_rdata;
          sticky_d = sticky_q | x_err;
          state_d  = (x_err || !need1_q) ? S_RESP : S_BEAT1;
        end
      end
      S_BEAT1: begin
        if (x_gnt) begin
          if (!wen_q) acc_d[63 -: EXT_DW] = x_rdata;
          sticky_d = sticky_q | x_err;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = hold_q ? S_RESP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Request capture, accumulators and registered outputs on both sides.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rtype_q  <= 1'b0;
      wen_q    <= 1'b0;
      need1_q  <= 1'b0;
      addr_q   <= '0;
      strb_q   <= '0;
      wdata_q  <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      c_gnt    <= 1'b0;
      c_err    <= 1'b0;
      c_rdata  <= '0;
      x_req    <= 1'b0;
      x_rtype  <= 1'b0;
      x_addr   <= '0;
      x_wen    <= 1'b0;
      x_strb   <= '0;
      x_wdata  <= '0;
    end else begin
      if (state_q == S_IDLE && c_req) begin
        rtype_q <= c_rtype;
        wen_q   <= c_wen;
        need1_q <= need1;
        addr_q  <= c_addr[ADDR_W-1:3];
        strb_q  <= c_strb;
        wdata_q <= c_wdata;
      end
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      c_gnt    <= (state_d == S_RESP) && !hold_d;
      if ((state_d == S_RESP) && !hold_d) begin
        c_rdata <= acc_d;
        c_err   <= sticky_d;
      end
      x_req <= (state_d == S_BEAT0) || (state_d == S_BEAT1);
      if ((state_d == S_BEAT0) || (state_d == S_BEAT1)) begin
        x_rtype <= src_rtype;
        x_wen   <= src_wen;
        x_addr  <= {src_addr, (state_d == S_BEAT1), 2'b00};
        x_strb  <= (state_d == S_BEAT1) ? slc_strb1 : slc_strb0;
        x_wdata <= (state_d == S_BEAT1) ? slc_wd1 : slc_wd0;
      end
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ccx_emem_width_bridge.sv
// Testbench for ccx_emem_width_bridge: a 32-bit instance driven against a
// scripted external slave with expected-beat and expected-response queues,
// plus a 64-bit instance with a zero-wait slave.
module tb_ccx_emem_width_bridge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- 32-bit DUT ----------------
  logic        c_req, c_rtype, c_wen, c_gnt, c_err;
  logic [38:0] c_addr;
  logic [7:0]  c_strb;
  logic [63:0] c_wdata, c_rdata;
  logic        x_req, x_rtype, x_wen, x_gnt, x_err, busy;
  logic [38:0] x_addr;
  logic [3:0]  x_strb;
  logic [31:0] x_wdata, x_rdata;

  ccx_emem_width_bridge #(.ADDR_W(39), .EXT_DW(32), .SKIP_EMPTY_BEATS(1'b1)) dut32 (
    .g_clk(clk), .g_resetn(rst_n),
    .c_req(c_req), .c_rtype(c_rtype), .c_addr(c_addr), .c_wen(c_wen),
    .c_strb(c_strb), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_err(c_err), .c_rdata(c_rdata),
    .x_req(x_req), .x_rtype(x_rtype), .x_addr(x_addr), .x_wen(x_wen),
    .x_strb(x_strb), .x_wdata(x_wdata), .x_gnt(x_gnt), .x_err(x_err), .x_rdata(x_rdata),
    .busy(busy)
  );

  // ---------------- 64-bit DUT ----------------
  logic        c64_req, c64_rtype, c64_wen, c64_gnt, c64_err;
  logic [38:0] c64_addr;
  logic [7:0]  c64_strb;
  logic [63:0] c64_wdata, c64_rdata;
  logic        x64_req, x64_rtype, x64_wen, x64_gnt, x64_err, busy64;
  logic [38:0] x64_addr;
  logic [7:0]  x64_strb;
  logic [63:0] x64_wdata, x64_rdata;

  ccx_emem_width_bridge #(.ADDR_W(39), .EXT_DW(64), .SKIP_EMPTY_BEATS(1'b1)) dut64 (
    .g_clk(clk), .g_resetn(rst_n),
    .c_req(c64_req), .c_rtype(c64_rtype), .c_addr(c64_addr), .c_wen(c64_wen),
    .c_strb(c64_strb), .c_wdata(c64_wdata), .c_gnt(c64_gnt), .c_err(c64_err), .c_rdata(c64_rdata),
    .x_req(x64_req), .x_rtype(x64_rtype), .x_addr(x64_addr), .x_wen(x64_wen),
    .x_strb(x64_strb), .x_wdata(x64_wdata), .x_gnt(x64_gnt), .x_err(x64_err), .x_rdata(x64_rdata),
    .busy(busy64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct packed {
    logic [38:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        wen;
    logic        rtype;
  } beat_t;
  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [7:0]  wait_n;
  } rsp_t;

  beat_t       eb_q[$];
  rsp_t        rsp_q[$];
  logic [64:0] exp_q[$];
  int          exp_lat_q[$];
  int          t0 = 0;

  task automatic push_beat(input logic [38:0] a, input logic [3:0] s, input logic [31:0] d,
                           input logic w, input logic r);
    eb_q.push_back('{addr: a, strb: s, wdata: d, wen: w, rtype: r});
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic e, input logic [7:0] w);
    rsp_q.push_back('{data: d, err: e, wait_n: w});
  endtask

  // ---------------- 32-bit external slave ----------------
  int          s_cnt = 0;
  int          s_wait = 0;
  logic [38:0] s_addr;
  logic [3:0]  s_strb;
  logic [31:0] s_wdata;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      x_gnt = 1'b0; x_err = 1'b0; x_rdata = '0; s_cnt = 0;
    end else begin
      if (x_gnt) begin
        x_gnt = 1'b0; x_err = 1'b0; s_cnt = 0;
      end
      if (x_req) begin
        if (s_cnt == 0) begin
          chk("beat_expected", 64'(eb_q.size() != 0), 64'd1);
          if (eb_q.size() != 0) begin
            beat_t b;
            b = eb_q.pop_front();
            chk("x_addr", 64'(x_addr), 64'(b.addr));
            chk("x_strb", 64'(x_strb), 64'(b.strb));
            chk("x_wdata", 64'(x_wdata), 64'(b.wdata));
            chk("x_wen", 64'(x_wen), 64'(b.wen));
            chk("x_rtype", 64'(x_rtype), 64'(b.rtype));
          end
          s_addr = x_addr; s_strb = x_strb; s_wdata = x_wdata;
          s_wait = (rsp_q.size() != 0) ? int'(rsp_q[0].wait_n) : 0;
        end else begin
          chk("x_addr_stable", 64'(x_addr), 64'(s_addr));
          chk("x_strb_stable", 64'(x_strb), 64'(s_strb));
          chk("x_wdata_stable", 64'(x_wdata), 64'(s_wdata));
        end
        if (s_cnt == s_wait) begin
          x_gnt = 1'b1;
          if (rsp_q.size() != 0) begin
            rsp_t r;
            r = rsp_q.pop_front();
            x_rdata = r.data; x_err = r.err;
          end else begin
            x_rdata = '0; x_err = 1'b0;
          end
        end else begin
          s_cnt++;
        end
      end
    end
  end

  // ---------------- 32-bit response monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && c_gnt === 1'b1) begin
      chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [64:0] e;
        int          l;
        e = exp_q.pop_front();
        l = exp_lat_q.pop_front();
        chk("c_rdata", c_rdata, e[63:0]);
        chk("c_err", 64'(c_err), 64'(e[64]));
        chk("gnt_latency", 64'(cyc - t0), 64'(l));
      end
    end
  end

  // ---------------- 64-bit zero-wait slave ----------------
  int          b64_cnt = 0;
  logic [38:0] b64_addr;
  logic [7:0]  b64_strb;
  logic [63:0] b64_wdata;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      x64_gnt = 1'b0;
    end else begin
      x64_gnt = x64_req;
      if (x64_req) begin
        b64_cnt++;
        b64_addr = x64_addr; b64_strb = x64_strb; b64_wdata = x64_wdata;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req32(input logic rtype, input logic wen, input logic [38:0] addr,
                          input logic [7:0] strb, input logic [63:0] wdata,
                          input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat);
    int n;
    @(negedge clk);
    c_req = 1'b1; c_rtype = rtype; c_wen = wen; c_addr = addr; c_strb = strb; c_wdata = wdata;
    t0 = cyc;
    exp_q.push_back({exp_err, exp_rdata});
    exp_lat_q.push_back(exp_lat);
    n = 0;
    do begin @(negedge clk); n++; end while (!c_gnt && n < 100);
    chk("gnt_in_time", 64'(n < 100), 64'd1);
    c_req = 1'b0;
    @(negedge clk);
    chk("gnt_single", 64'(c_gnt), 64'd0);
    chk("rdata_hold", c_rdata, exp_rdata);
    chk("err_hold", 64'(c_err), 64'(exp_err));
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic do_req64(input logic wen, input logic [38:0] addr, input logic [7:0] strb,
                          input logic [63:0] wdata, input int exp_beats, input logic [38:0] exp_addr,
                          input logic [63:0] exp_rdata, input int exp_lat);
    int n, b0, ts;
    @(negedge clk);
    b0 = b64_cnt;
    c64_req = 1'b1; c64_rtype = 1'b1; c64_wen = wen; c64_addr = addr; c64_strb = strb; c64_wdata = wdata;
    ts = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!c64_gnt && n < 100);
    chk("gnt64_in_time", 64'(n < 100), 64'd1);
    chk("gnt64_latency", 64'(cyc - ts), 64'(exp_lat));
    chk("c64_rdata", c64_rdata, exp_rdata);
    chk("c64_err", 64'(c64_err), 64'd0);
    c64_req = 1'b0;
    @(negedge clk);
    chk("beats64", 64'(b64_cnt - b0), 64'(exp_beats));
    if (exp_beats != 0) begin
      chk("x64_addr", 64'(b64_addr), 64'(exp_addr));
      chk("x64_strb", 64'(b64_strb), 64'(strb));
      chk("x64_wdata", b64_wdata, wdata);
    end
    chk("gnt64_single", 64'(c64_gnt), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          n;
    logic [63:0] r64;
    logic [38:0] ra;
    logic [31:0] d0, d1;
    int          w0, w1;

    rst_n = 1'b0;
    c_req = 0; c_rtype = 0; c_wen = 0; c_addr = '0; c_strb = '0; c_wdata = '0;
    c64_req = 0; c64_rtype = 0; c64_wen = 0; c64_addr = '0; c64_strb = '0; c64_wdata = '0;
    x64_err = 1'b0; x64_rdata = 64'h0123_4567_89AB_CDEF;
    repeat (3) @(negedge clk);
    chk("rst_c_gnt", 64'(c_gnt), 64'd0);
    chk("rst_c_err", 64'(c_err), 64'd0);
    chk("rst_c_rdata", c_rdata, 64'd0);
    chk("rst_x_req", 64'(x_req), 64'd0);
    chk("rst_x_addr", 64'(x_addr), 64'd0);
    chk("rst_x_strb", 64'(x_strb), 64'd0);
    chk("rst_x_wdata", 64'(x_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_x64_req", 64'(x64_req), 64'd0);
    chk("rst_c64_gnt", 64'(c64_gnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned split read, zero wait.
    push_beat(39'h10, 4'h0, 32'h0, 1'b0, 1'b0);
    push_beat(39'h14, 4'h0, 32'h0, 1'b0, 1'b0);
    push_rsp(32'hDDCCBBAA, 1'b0, 8'd0);
    push_rsp(32'h44332211, 1'b0, 8'd0);
    do_req32(1'b0, 1'b0, 39'h10, 8'h00, 64'h0, 64'h44332211_DDCCBBAA, 1'b0, 3);

    // Write with empty upper half: one beat, no read-data merge.
    push_beat(39'h20, 4'hF, 32'hCAFEBABE, 1'b1, 1'b1);
    push_rsp(32'hFFFF0000, 1'b0, 8'd0);
    do_req32(1'b1, 1'b1, 39'h20, 8'h0F, 64'h11111111_CAFEBABE, 64'h0, 1'b0, 2);

    // Write with empty lower half: only the upper beat.
    push_beat(39'h2C, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1);
    push_rsp(32'h0, 1'b0, 8'd0);
    do_req32(1'b1, 1'b1, 39'h28, 8'hF0, 64'hDEADBEEF_12345678, 64'h0, 1'b0, 2);

    // Fully empty write: no beats.
    do_req32(1'b1, 1'b1, 39'h38, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 2);

    // Error on the first beat aborts the second.
    push_beat(39'h40, 4'h0, 32'h0, 1'b0, 1'b0);
    push_rsp(32'h12345678, 1'b1, 8'd0);
    do_req32(1'b0, 1'b0, 39'h44, 8'h00, 64'h0, 64'h00000000_12345678, 1'b1, 2);

    // Error on the second beat, which also waits one cycle.
    push_beat(39'h48, 4'h0, 32'h0, 1'b0, 1'b1);
    push_beat(39'h4C, 4'h0, 32'h0, 1'b0, 1'b1);
    push_rsp(32'hAAAA5555, 1'b0, 8'd0);
    push_rsp(32'h99991111, 1'b1, 8'd1);
    do_req32(1'b1, 1'b0, 39'h48, 8'h00, 64'h0, 64'h99991111_AAAA5555, 1'b1, 4);

    // Two-beat partial write.
    push_beat(39'h50, 4'hC, 32'h89ABCDEF, 1'b1, 1'b0);
    push_beat(39'h54, 4'h3, 32'h01234567, 1'b1, 1'b0);
    push_rsp(32'h0, 1'b0, 8'd0);
    push_rsp(32'h0, 1'b0, 8'd0);
    do_req32(1'b0, 1'b1, 39'h53, 8'h3C, 64'h01234567_89ABCDEF, 64'h0, 1'b0, 3);

    // Five wait states on each beat.
    push_beat(39'h60, 4'h0, 32'h0, 1'b0, 1'b0);
    push_beat(39'h64, 4'h0, 32'h0, 1'b0, 1'b0);
    push_rsp(32'h0BADF00D, 1'b0, 8'd5);
    push_rsp(32'h600DCAFE, 1'b0, 8'd5);
    do_req32(1'b0, 1'b0, 39'h60, 8'h00, 64'h0, 64'h600DCAFE_0BADF00D, 1'b0, 13);

    // Random reads with random wait states.
    for (int i = 0; i < 6; i++) begin
      r64 = {$urandom, $urandom};
      ra  = r64[38:0];
      d0  = $urandom; d1 = $urandom;
      w0  = $urandom_range(0, 3); w1 = $urandom_range(0, 3);
      push_beat({ra[38:3], 3'b000}, 4'h0, 32'h0, 1'b0, 1'b1);
      push_beat({ra[38:3], 3'b100}, 4'h0, 32'h0, 1'b0, 1'b1);
      push_rsp(d0, 1'b0, 8'(w0));
      push_rsp(d1, 1'b0, 8'(w1));
      do_req32(1'b1, 1'b0, ra, 8'h00, 64'h0, {d1, d0}, 1'b0, w0 + w1 + 3);
    end

    // Reset while the second beat is waiting.
    push_beat(39'h80, 4'h0, 32'h0, 1'b0, 1'b0);
    push_beat(39'h84, 4'h0, 32'h0, 1'b0, 1'b0);
    push_rsp(32'h1, 1'b0, 8'd0);
    push_rsp(32'h2, 1'b0, 8'd50);
    @(negedge clk);
    c_req = 1'b1; c_rtype = 1'b0; c_wen = 1'b0; c_addr = 39'h80; c_strb = '0; c_wdata = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(x_req && x_addr[2]) && n < 50);
    chk("beat1_reached", 64'(x_req && x_addr[2]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_x_req", 64'(x_req), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_c_gnt", 64'(c_gnt), 64'd0);
    c_req = 1'b0;
    repeat (2) @(negedge clk);
    rsp_q.delete();
    eb_q.delete();
    chk("rst_hold_c_gnt", 64'(c_gnt), 64'd0);
    rst_n = 1'b1;

    // Normal read after reset.
    push_beat(39'h70, 4'h0, 32'h0, 1'b0, 1'b0);
    push_beat(39'h74, 4'h0, 32'h0, 1'b0, 1'b0);
    push_rsp(32'h55667788, 1'b0, 8'd0);
    push_rsp(32'h11223344, 1'b0, 8'd0);
    do_req32(1'b0, 1'b0, 39'h70, 8'h00, 64'h0, 64'h11223344_55667788, 1'b0, 3);

    // 64-bit bus: pass-through beats and elided empty write.
    do_req64(1'b1, 39'h1_0005, 8'hFF, 64'hA1B2C3D4_E5F60718, 1, 39'h1_0000, 64'h0, 2);
    do_req64(1'b1, 39'h1_0008, 8'h00, 64'h1234, 0, 39'h0, 64'h0, 2);
    do_req64(1'b0, 39'h20F, 8'h00, 64'h0, 1, 39'h208, 64'h0123_4567_89AB_CDEF, 2);

    chk("beats_drained", 64'(eb_q.size()), 64'd0);
    chk("resps_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccx_emem_width_bridge.md
# ccx_emem_width_bridge

Parametrised bridge between the core's 64-bit external memory port and an external bus of configurable data width (32 or 64 bits). It sits between the `emem_*` port of the core top level and the SoC interconnect. Each 64-bit core access is split into one or two registered external beats. Responses are merged, and errors are made sticky across beats. Empty write beats can optionally be elided.

## Interface
Parameters:
- `ADDR_W`, 39, byte-address width on both sides.
- `EXT_DW`, 32, external data width; legal values are 32 and 64 only (any other value is an elaboration error).
- `SKIP_EMPTY_BEATS`, 1, when 1 a write beat whose strobe slice is all-zero is not issued.

Ports:
- `g_clk`  in  1  clock; all state changes on its rising edge.
- `g_resetn`  in  1  reset, asynchronous assert, active-low.
- `c_req`  in  1  core request; held with all `c_*` request fields stable until `c_gnt`.
- `c_rtype`  in  1  request type (instruction/data), forwarded unchanged.
- `c_addr`  in  ADDR_W  byte address.
- `c_wen`  in  1  write enable.
- `c_strb`  in  8  write byte strobes.
- `c_wdata`  in  64  write data.
- `c_gnt`  out  1  single-cycle response; `c_rdata` and `c_err` are valid in this cycle.
- `c_err`  out  1  response error.
- `c_rdata`  out  64  read data.
- `x_req`  out  1  external beat request; held until `x_gnt`.
- `x_rtype`  out  1  forwarded `c_rtype`.
- `x_addr`  out  ADDR_W  beat address, aligned to EXT_DW/8.
- `x_wen`  out  1  beat write enable.
- `x_strb`  out  EXT_DW/8  beat strobes.
- `x_wdata`  out  EXT_DW  beat write data.
- `x_gnt`  in  1  external beat response; `x_rdata` and `x_err` are valid in this cycle.
- `x_err`  in  1  beat error.
- `x_rdata`  in  EXT_DW  beat read data.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP. BEAT1 is only reachable when EXT_DW=32.
- **IDLE, `c_req`=1:** capture `rtype`, `addr`, `wen`, `strb` and `wdata`. Clear the response data register and the sticky error. Go to the first beat that is required.
- **IDLE, `c_req`=0:** stay in IDLE.
- **Beat required (EXT_DW=32):** BEATn is required unless `SKIP_EMPTY_BEATS`=1, `wen`=1 and `strb[4n+3:4n]`=0. Reads always issue both beats.
- **Beat required (EXT_DW=64):** BEAT0 is always required, except a write with `strb`=0 when `SKIP_EMPTY_BEATS`=1.
- **No beat required:** go straight to RESP with `c_err`=0.
- **Beat address:** EXT_DW=32 gives `{addr[ADDR_W-1:3], n, 2'b00}`. EXT_DW=64 gives `{addr[ADDR_W-1:3], 3'b000}`.
- **Beat strobe and data (EXT_DW=32):** strobe slice `strb[4n+3:4n]`, data slice `wdata[32n+31:32n]`.
- **Beat strobe and data (EXT_DW=64):** pass `strb` and `wdata` through unchanged.
- **BEATn:** drive `x_req`=1. On `x_gnt`, write `x_rdata` into the matching `c_rdata` slice (reads only) and OR `x_err` into the sticky error.
- **Next state after a BEATn grant:**
  - Go to RESP if `x_err`=1; the remaining beat is aborted.
  - Go to RESP if this is the last required beat.
  - Otherwise go to BEAT1.
- **Read data of aborted or skipped beats:** the corresponding slice reads 0.
- **RESP:** `c_gnt`=1 for exactly one cycle, with `c_err` equal to the sticky error. Then return to IDLE.
- **Core request fields while busy:** ignored. `c_req` sampled in the cycle after RESP is treated as a new request.
- **Registered outputs:** every `x_*` output and every `c_*` output comes from a register; there is no combinational path from input to output.
- **Outputs outside a response:** `c_rdata` and `c_err` hold their last value outside `c_gnt` cycles.
- **Reset:**
  - Every output resets to 0 and the FSM resets to IDLE.
  - Asserting `g_resetn` mid-transaction drops `x_req` asynchronously.
  - No `c_gnt` is issued for the in-flight request.

## Timing
- **Core request to first external beat:** 1 cycle (`c_req` in cycle 0 gives `x_req` in cycle 1).
- **Back-to-back beats:** the next beat's `x_req` is asserted in the cycle after the previous `x_gnt`. `x_req` deasserts for no cycle in between, but `x_addr`, `x_strb` and `x_wdata` change.
- **Last grant to core response:** `c_gnt` arrives 1 cycle after the last `x_gnt`.
- **Zero-wait external slave:** a two-beat access gives `c_gnt` in cycle 3; a one-beat access gives `c_gnt` in cycle 2.
- **Fully skipped write:** `c_gnt` in cycle 2.
- **Turnaround:** at most one transaction in flight. IDLE lasts at least 1 cycle between transactions.
- **External wait states:** unbounded wait on `x_gnt` is allowed; all `x_*` outputs remain stable while `x_req`=1 and `x_gnt`=0.

## Test plan
- **Aligned 32-bit split read:** EXT_DW=32, read at `addr`=0x10. Beat0 returns 0xDDCCBBAA and beat1 returns 0x44332211, both with zero wait. Required: `x_addr` = 0x10 then 0x14; `c_rdata`=0x44332211_DDCCBBAA; `c_gnt` in cycle 3; `c_err`=0.
- **Empty upper write beat:** EXT_DW=32, write `strb`=0x0F, `wdata`=0x11111111_CAFEBABE, `SKIP_EMPTY_BEATS`=1. Required: exactly one beat at `x_addr`=0x...0 with `x_strb`=0xF and `x_wdata`=0xCAFEBABE; `c_gnt` in cycle 2.
- **Error on first beat:** read where beat0 returns `x_err`=1. Required: no beat1 issued; `c_err`=1; `c_rdata`[63:32]=0.
- **Wait states:** `x_gnt` held low for 5 cycles on each beat. Required: `x_*` outputs stable while waiting; `c_gnt` asserted exactly once, 1 cycle after the second `x_gnt`.
- **EXT_DW=64 pass-through:** unaligned `c_addr`=0x1_0005, write `strb`=0xFF. Required: one beat with `x_addr`=0x1_0000 and `x_strb`=0xFF; a fully empty write (`strb`=0) issues no beat and returns `c_gnt` with `c_err`=0.
- **Reset mid-operation:** assert `g_resetn`=0 while BEAT1 `x_req` is high. Required: `x_req`, `busy` and `c_gnt` go to 0 immediately; after release, a new read completes normally.
